// File: rtl/apb_master_asynch.sv
// Source-clock half of an APB clock-domain crossing. Accepts a local APB
// access, freezes it onto a quasi-static async bus and runs a 4-phase
// req/ack handshake with the destination-side half. PREADY is returned
// only once the handshake has fully returned to idle.
//
// state         | meaning
// --------------+------------------------------------------------------
// IDLE          | waiting for PSEL with ack_sync low; async bus may load
// WAIT_ACK_HIGH | req high, bus frozen, waiting for far side to ack
// WAIT_ACK_LOW  | response captured, req low, waiting for ack to drop
// DONE          | PREADY pulse to the local master for one cycle
module apb_master_asynch #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR_i,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA_i,
  input  logic                      PWRITE_i,
  input  logic                      PSEL_i,
  input  logic                      PENABLE_i,
  output logic [APB_DATA_WIDTH-1:0] PRDATA_o,
  output logic                      PREADY_o,
  output logic                      PSLVERR_o,
  output logic                      asynch_req_o,
  input  logic                      asynch_ack_i,
  output logic [APB_ADDR_WIDTH-1:0] async_PADDR_o,
  output logic [APB_DATA_WIDTH-1:0] async_PWDATA_o,
  output logic                      async_PWRITE_o,
  output logic                      async_PSEL_o,
  input  logic [APB_DATA_WIDTH-1:0] async_PRDATA_i,
  input  logic                      async_PSLVERR_i
);

  localparam logic [1:0] IDLE          = 2'd0;
  localparam logic [1:0] WAIT_ACK_HIGH = 2'd1;
  localparam logic [1:0] WAIT_ACK_LOW  = 2'd2;
  localparam logic [1:0] DONE          = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [SYNC_STAGES-1:0]    sync_q, sync_d;
  logic                      req_q, req_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                      err_q, err_d;
  logic                      ack_sync;

  // Transfers start on PSEL alone; PENABLE carries no information here.
  logic penable_unused;
  assign penable_unused = PENABLE_i;

  // Shift the raw acknowledge through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], asynch_ack_i};
  end

  assign ack_sync = sync_q[SYNC_STAGES-1];

  // Handshake sequencing and capture of request/response fields.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    psel_d   = psel_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        // A stale ack (e.g. left over from a reset mid-handshake) holds
        // the access off, so the bus only changes while req and ack are low.
        if (PSEL_i && !ack_sync) begin
          paddr_d  = PADDR_i;
          pwdata_d = PWDATA_i;
          pwrite_d = PWRITE_i;
          psel_d   = PSEL_i;
          req_d    = 1'b1;
          state_d  = WAIT_ACK_HIGH;
        end
      end
      WAIT_ACK_HIGH: begin
        // Response fields are held stable by the far side while ack is high.
        if (ack_sync) begin
          prdata_d = async_PRDATA_i;
          err_d    = async_PSLVERR_i;
          req_d    = 1'b0;
          state_d  = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_sync) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      req_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      psel_q   <= 1'b0;
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      req_q    <= req_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      psel_q   <= psel_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

  assign asynch_req_o   = req_q;
  assign async_PADDR_o  = paddr_q;
  assign async_PWDATA_o = pwdata_q;
  assign async_PWRITE_o = pwrite_q;
  assign async_PSEL_o   = psel_q;
  assign PRDATA_o       = prdata_q;
  assign PREADY_o       = (state_q == DONE);
  assign PSLVERR_o      = (state_q == DONE) && err_q;

endmodule
